// File: rtl/axi4_ram_if.sv
// AXI4 bus bundle between a master and the axi4_ram slave memory.
// Carries all five channels; clock and reset travel as plain ports.
interface axi4_ram_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4_ram.sv
// AXI4 slave RAM: word-addressed array with independent single-outstanding
// read and write burst engines, always answering OKAY.
module axi4_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input logic       clk,
    input logic       rst_n,
    axi4_ram_if.slave s_axi
);
    localparam int OFFS_W = $clog2(STRB_WIDTH);
    localparam int WORDS  = (2 ** ADDR_WIDTH) / STRB_WIDTH;
    localparam int WIDX_W = ADDR_WIDTH - OFFS_W;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        // WRAP and the reserved encoding both behave as INCR
        if (burst == 2'b00) return addr;
        return addr + (ADDR_WIDTH'(1) << size);
    endfunction

    function automatic logic [WIDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:OFFS_W];
    endfunction

    w_state_t              w_state, w_state_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d, w_id, w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr, w_addr_d;
    logic [7:0]            w_cnt, w_cnt_d;
    logic [2:0]            w_size, w_size_d;
    logic [1:0]            w_burst, w_burst_d;
    logic                  w_we;

    r_state_t              r_state, r_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_d, r_addr_nx;
    logic [7:0]            r_cnt, r_cnt_d;
    logic [2:0]            r_size, r_size_d;
    logic [1:0]            r_burst, r_burst_d;

    logic unused_in;
    assign unused_in = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot,
                         s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.wlast};

    // Write engine: w_cnt counts beats still expected after the current one
    always_comb begin
        w_state_d = w_state;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        w_id_d    = w_id;
        w_addr_d  = w_addr;
        w_cnt_d   = w_cnt;
        w_size_d  = w_size;
        w_burst_d = w_burst;
        w_we      = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awready_q && s_axi.awvalid) begin
                    w_id_d    = s_axi.awid;
                    w_addr_d  = s_axi.awaddr;
                    w_cnt_d   = s_axi.awlen;
                    w_size_d  = s_axi.awsize;
                    w_burst_d = s_axi.awburst;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wready_q && s_axi.wvalid) begin
                    w_we     = 1'b1;
                    w_addr_d = next_addr(w_addr, w_size, w_burst);
                    if (w_cnt == 8'd0) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt - 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && s_axi.bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
        end else begin
            w_state   <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
        end
    end

    always_ff @(posedge clk) begin
        w_id    <= w_id_d;
        w_addr  <= w_addr_d;
        w_cnt   <= w_cnt_d;
        w_size  <= w_size_d;
        w_burst <= w_burst_d;
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi.wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= s_axi.wdata[8*i +: 8];
            end
        end
    end

    // Read engine: the next word is fetched when a beat is accepted, so the
    // presented beat stays frozen during a stall
    always_comb begin
        r_state_d = r_state;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        r_addr_d  = r_addr;
        r_cnt_d   = r_cnt;
        r_size_d  = r_size;
        r_burst_d = r_burst;
        r_addr_nx = next_addr(r_addr, r_size, r_burst);
        case (r_state)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arready_q && s_axi.arvalid) begin
                    r_addr_d  = s_axi.araddr;
                    r_cnt_d   = s_axi.arlen;
                    r_size_d  = s_axi.arsize;
                    r_burst_d = s_axi.arburst;
                    rid_d     = s_axi.arid;
                    rdata_d   = mem[word_idx(s_axi.araddr)];
                    rlast_d   = (s_axi.arlen == 8'd0);
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && s_axi.rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = r_addr_nx;
                        rdata_d  = mem[word_idx(r_addr_nx)];
                        r_cnt_d  = r_cnt - 8'd1;
                        rlast_d  = (r_cnt == 8'd1);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
        end else begin
            r_state   <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        r_addr  <= r_addr_d;
        r_cnt   <= r_cnt_d;
        r_size  <= r_size_d;
        r_burst <= r_burst_d;
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;
endmodule

// File: tb/tb_axi4_ram.sv
// Scoreboard bench for axi4_ram: a byte-array model predicts B and R
// responses, and a negedge monitor checks them as the DUT presents them.
module tb_axi4_ram;
    localparam int DW = 64;
    localparam int AW = 16;
    localparam int IW = 8;
    localparam int SB = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi4_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bif ();

    axi4_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (bif.slave)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } rexp_t;

    int            n_chk = 0;
    int            n_bad = 0;
    logic [IW-1:0] bq[$];
    rexp_t         rq[$];
    logic [7:0]    mdl [0:65535];
    logic [DW-1:0] wd [0:255];
    logic [SB-1:0] ws [0:255];
    logic          rnd_rdy = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_bad++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Byte address of beat b: FIXED stays put, everything else steps by 2^size
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input logic [2:0] size,
                                                input logic [1:0] burst, input int b);
        if (burst == 2'b00) return a;
        return AW'(int'(a) + b * (1 << size));
    endfunction

    function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        logic [AW-1:0] base;
        base = a & ~AW'(SB - 1);
        for (int i = 0; i < SB; i++) w[8*i +: 8] = mdl[AW'(int'(base) + i)];
        return w;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SB-1:0] s);
        logic [AW-1:0] base;
        base = a & ~AW'(SB - 1);
        for (int i = 0; i < SB; i++) if (s[i]) mdl[AW'(int'(base) + i)] = d[8*i +: 8];
    endtask

    function automatic logic rdy(input int ch);
        case (ch)
            0:       return bif.awready;
            1:       return bif.wready;
            default: return bif.arready;
        endcase
    endfunction

    // Holds valid until the ready seen before an edge; returns #1 after that edge
    task automatic wait_hs(input int ch, input string name);
        int t = 0;
        @(negedge clk);
        while (!rdy(ch) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) timeout(name);
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input bit gaps);
        int t;
        bq.push_back(id);
        bif.awid = id; bif.awaddr = a; bif.awlen = len; bif.awsize = size; bif.awburst = burst;
        bif.awvalid = 1'b1;
        wait_hs(0, "aw_hs");
        bif.awvalid = 1'b0;
        check("wready_after_aw", bif.wready, 1);
        for (int b = 0; b <= int'(len); b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bif.wvalid = 1'b0;
                @(posedge clk); #1;
            end
            bif.wdata = wd[b]; bif.wstrb = ws[b]; bif.wlast = (b == int'(len));
            bif.wvalid = 1'b1;
            wait_hs(1, "w_hs");
            model_write(beat_addr(a, size, burst, b), wd[b], ws[b]);
        end
        bif.wvalid = 1'b0;
        bif.wlast = 1'b0;
        check("bvalid_after_last_w", bif.bvalid, 1);
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (bq.size() != 0 && t < 2000);
        #1;
        if (bq.size() != 0) begin
            timeout("b_resp");
            bq.delete();
        end else begin
            check("awready_after_b", bif.awready, 1);
            check("bvalid_clear_after_b", bif.bvalid, 0);
        end
    endtask

    task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        rexp_t e;
        int    t;
        for (int b = 0; b <= int'(len); b++) begin
            e.id = id;
            e.data = model_word(beat_addr(a, size, burst, b));
            e.last = (b == int'(len));
            rq.push_back(e);
        end
        bif.arid = id; bif.araddr = a; bif.arlen = len; bif.arsize = size; bif.arburst = burst;
        bif.arvalid = 1'b1;
        wait_hs(2, "ar_hs");
        bif.arvalid = 1'b0;
        check("rvalid_after_ar", bif.rvalid, 1);
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while (rq.size() != 0 && t < 2000);
        #1;
        if (rq.size() != 0) begin
            timeout("r_data");
            rq.delete();
        end else begin
            check("arready_after_rlast", bif.arready, 1);
            check("rvalid_clear_after_rlast", bif.rvalid, 0);
        end
    endtask

    // Monitor: compares every presented beat, pops on handshake
    always @(negedge clk) begin
        if (rst_n && bif.bvalid && bif.bready) begin
            if (bq.size() == 0) begin
                timeout("b_unexpected");
            end else begin
                check("bid", bif.bid, bq[0]);
                check("bresp", bif.bresp, 2'b00);
                void'(bq.pop_front());
            end
        end
        if (rst_n && bif.rvalid) begin
            if (rq.size() == 0) begin
                timeout("r_unexpected");
            end else begin
                check("rid", bif.rid, rq[0].id);
                check("rdata", bif.rdata, rq[0].data);
                check("rlast", bif.rlast, rq[0].last);
                check("rresp", bif.rresp, 2'b00);
                if (bif.rready) void'(rq.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) begin
                bif.bready = ($urandom_range(0, 3) != 0);
                bif.rready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        bif.awid = '0; bif.awaddr = '0; bif.awlen = '0; bif.awsize = '0; bif.awburst = '0;
        bif.awlock = 1'b0; bif.awcache = '0; bif.awprot = '0; bif.awvalid = 1'b0;
        bif.wdata = '0; bif.wstrb = '0; bif.wlast = 1'b0; bif.wvalid = 1'b0;
        bif.bready = 1'b1;
        bif.arid = '0; bif.araddr = '0; bif.arlen = '0; bif.arsize = '0; bif.arburst = '0;
        bif.arlock = 1'b0; bif.arcache = '0; bif.arprot = '0; bif.arvalid = 1'b0;
        bif.rready = 1'b1;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_awready", bif.awready, 0);
        check("rst_wready", bif.wready, 0);
        check("rst_bvalid", bif.bvalid, 0);
        check("rst_arready", bif.arready, 0);
        check("rst_rvalid", bif.rvalid, 0);
        check("rst_rlast", bif.rlast, 0);
        check("rst_bid_bresp", {bif.bid, bif.bresp}, 0);
        check("rst_rid_rresp", {bif.rid, bif.rresp}, 0);
        check("rst_rdata", bif.rdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("awready_after_release", bif.awready, 1);
        check("arready_after_release", bif.arready, 1);

        // Fill the low 4 KiB so every later read has a known expectation
        for (int blk = 0; blk < 2; blk++) begin
            for (int b = 0; b < 256; b++) begin
                wd[b] = {$urandom, $urandom};
                ws[b] = '1;
            end
            axi_write(8'd1, AW'(blk * 16'h0800), 8'd255, 3'd3, 2'b01, 1'b0);
        end

        wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
        axi_write(8'd5, 16'h0010, 8'd0, 3'd3, 2'b01, 1'b0);
        axi_read(8'd5, 16'h0010, 8'd0, 3'd3, 2'b01);

        for (int b = 0; b < 4; b++) begin
            wd[b] = DW'(8'hA0 + b);
            ws[b] = 8'hFF;
        end
        axi_write(8'd7, 16'h0100, 8'd3, 3'd3, 2'b01, 1'b0);
        axi_read(8'd7, 16'h0100, 8'd3, 3'd3, 2'b01);

        wd[0] = '1; ws[0] = 8'hFF;
        axi_write(8'd2, 16'h0400, 8'd0, 3'd3, 2'b01, 1'b0);
        wd[0] = '0; ws[0] = 8'h0F;
        axi_write(8'd3, 16'h0400, 8'd0, 3'd3, 2'b01, 1'b0);
        check("strobe_model", model_word(16'h0400), 64'hFFFFFFFF00000000);
        axi_read(8'd3, 16'h0400, 8'd0, 3'd3, 2'b01);

        for (int b = 0; b < 3; b++) begin
            wd[b] = DW'(b + 1);
            ws[b] = 8'hFF;
        end
        axi_write(8'd4, 16'h0200, 8'd2, 3'd3, 2'b00, 1'b0);
        fork
            axi_read(8'd4, 16'h0200, 8'd2, 3'd3, 2'b00);
            begin
                repeat (2) @(posedge clk);
                #1 bif.rready = 1'b0;
                repeat (2) @(posedge clk);
                #1 bif.rready = 1'b1;
            end
        join

        // Address wrap across the top of the address space
        for (int b = 0; b < 4; b++) begin
            wd[b] = {$urandom, $urandom};
            ws[b] = 8'hFF;
        end
        axi_write(8'd6, 16'hFFF0, 8'd3, 3'd3, 2'b01, 1'b0);
        axi_read(8'd6, 16'hFFF0, 8'd3, 3'd3, 2'b01);

        // Reset in the middle of a write burst after two beats
        bif.awid = 8'd9; bif.awaddr = 16'h0300; bif.awlen = 8'd3; bif.awsize = 3'd3; bif.awburst = 2'b01;
        bif.awvalid = 1'b1;
        wait_hs(0, "abort_aw_hs");
        bif.awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wd[b] = {$urandom, $urandom};
            bif.wdata = wd[b]; bif.wstrb = 8'hFF; bif.wlast = 1'b0; bif.wvalid = 1'b1;
            wait_hs(1, "abort_w_hs");
            model_write(AW'(16'h0300 + 8 * b), wd[b], 8'hFF);
        end
        rst_n = 1'b0;
        bif.wvalid = 1'b0;
        #1;
        check("abort_wready", bif.wready, 0);
        check("abort_bvalid", bif.bvalid, 0);
        check("abort_awready", bif.awready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_awready_release", bif.awready, 1);
        axi_read(8'd9, 16'h0300, 8'd3, 3'd3, 2'b01);
        for (int b = 0; b < 2; b++) begin
            wd[b] = {$urandom, $urandom};
            ws[b] = 8'hFF;
        end
        axi_write(8'd10, 16'h0308, 8'd1, 3'd3, 2'b01, 1'b0);
        axi_read(8'd10, 16'h0300, 8'd3, 3'd3, 2'b01);

        // Independent channels: a read and a write to disjoint regions at once
        for (int b = 0; b < 8; b++) begin
            wd[b] = {$urandom, $urandom};
            ws[b] = SB'($urandom);
        end
        fork
            axi_write(8'd11, 16'h0600, 8'd7, 3'd3, 2'b01, 1'b1);
            axi_read(8'd12, 16'h0700, 8'd7, 3'd3, 2'b01);
        join
        axi_read(8'd13, 16'h0600, 8'd7, 3'd3, 2'b01);

        rnd_rdy = 1'b1;
        for (int it = 0; it < 60; it++) begin
            a = AW'($urandom_range(0, 16'h0E00));
            len = 8'($urandom_range(0, 15));
            size = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) begin
                for (int b = 0; b <= int'(len); b++) begin
                    wd[b] = {$urandom, $urandom};
                    ws[b] = SB'($urandom);
                end
                axi_write(IW'($urandom), a, len, size, burst, 1'b1);
            end else begin
                axi_read(IW'($urandom), a, len, size, burst);
            end
        end
        rnd_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
